// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I subset controller and its datapath muxes.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        HALT     = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'b00,
        SRC_A_OLD_PC = 2'b01,
        SRC_A_RS1    = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_RFUNCT = 2'b10,
        ALU_IFUNCT = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALU     = 2'b00,
        RES_ALU_OUT = 2'b01,
        RES_MEM     = 2'b10
    } result_src_t;

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive stalled memory request cycles; pulses expire on the
// last allowed stall cycle unless ready arrives in that same cycle.
module mem_watchdog
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ready,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count;

    // The TIMEOUT-th stalled cycle is the one in which count still reads TIMEOUT-1.
    assign expire = (TIMEOUT > 0) && req && !ready && (count == LAST);

    // Stall counter: clears whenever the request completes or is not active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!req || ready) begin
            count <= '0;
        end else if (!expire) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the RV32I subset (R, I-ALU, LW, SW, BEQ).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC + 4 when memory answers
// DECODE   | branch target (old_pc + imm) into alu_out, dispatch opcode
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm
// ALU_WB   | write alu_out to rd
// MEM_ADDR | rs1 + imm into alu_out
// MEM_RD   | load from alu_out address, wait for ready
// MEM_WB   | write load data to rd
// MEM_WR   | store to alu_out address, wait for ready
// BRANCH   | compare rs1/rs2, take target from alu_out on zero
// HALT     | unsupported opcode or memory timeout, wait for reset
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         result_src,
    output logic               illegal_instr,
    output logic               bus_error,
    output logic [STATE_W-1:0] state_o
);

    state_t      state;
    logic        req_raw, write_raw, ir_raw, pc_raw, reg_raw;
    alu_src_a_t  sel_a;
    alu_src_b_t  sel_b;
    alu_op_t     sel_op;
    result_src_t sel_res;
    logic        wd_expire;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_raw),
        .ready  (mem_ready),
        .expire (wd_expire)
    );

    // Output decode of the current state; FETCH and BRANCH enables also look at inputs.
    always_comb begin
        req_raw   = 1'b0;
        write_raw = 1'b0;
        adr_src   = 1'b0;
        ir_raw    = 1'b0;
        pc_raw    = 1'b0;
        reg_raw   = 1'b0;
        sel_a     = SRC_A_PC;
        sel_b     = SRC_B_RS2;
        sel_op    = ALU_ADD;
        sel_res   = RES_ALU;
        case (state)
            FETCH: begin
                req_raw = 1'b1;
                sel_b   = SRC_B_FOUR;
                ir_raw  = mem_ready;
                pc_raw  = mem_ready;
            end
            DECODE: begin
                sel_a = SRC_A_OLD_PC;
                sel_b = SRC_B_IMM;
            end
            EXEC_R: begin
                sel_a  = SRC_A_RS1;
                sel_op = ALU_RFUNCT;
            end
            EXEC_I: begin
                sel_a  = SRC_A_RS1;
                sel_b  = SRC_B_IMM;
                sel_op = ALU_IFUNCT;
            end
            ALU_WB: begin
                sel_res = RES_ALU_OUT;
                reg_raw = 1'b1;
            end
            MEM_ADDR: begin
                sel_a = SRC_A_RS1;
                sel_b = SRC_B_IMM;
            end
            MEM_RD: begin
                req_raw = 1'b1;
                adr_src = 1'b1;
            end
            MEM_WB: begin
                sel_res = RES_MEM;
                reg_raw = 1'b1;
            end
            MEM_WR: begin
                req_raw   = 1'b1;
                write_raw = 1'b1;
                adr_src   = 1'b1;
            end
            BRANCH: begin
                sel_a   = SRC_A_RS1;
                sel_op  = ALU_SUB;
                sel_res = RES_ALU_OUT;
                pc_raw  = zero;
            end
            default: ;
        endcase
    end

    // Reset gates the enables combinationally so a pending request drops at once.
    assign mem_req    = req_raw   & rst_n;
    assign mem_write  = write_raw & rst_n;
    assign ir_write   = ir_raw    & rst_n;
    assign pc_write   = pc_raw    & rst_n;
    assign reg_write  = reg_raw   & rst_n;
    assign alu_src_a  = sel_a;
    assign alu_src_b  = sel_b;
    assign alu_op     = sel_op;
    assign result_src = sel_res;
    assign state_o    = STATE_W'(state);

    // State sequencing and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        state <= DECODE;
                    end else if (wd_expire) begin
                        state     <= HALT;
                        bus_error <= 1'b1;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_R:                state <= EXEC_R;
                        OP_I:                state <= EXEC_I;
                        OP_LOAD, OP_STORE:   state <= MEM_ADDR;
                        OP_BRANCH:           state <= BRANCH;
                        default: begin
                            state         <= HALT;
                            illegal_instr <= 1'b1;
                        end
                    endcase
                end
                EXEC_R, EXEC_I: state <= ALU_WB;
                ALU_WB:         state <= FETCH;
                MEM_ADDR:       state <= (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
                MEM_RD: begin
                    if (mem_ready) begin
                        state <= MEM_WB;
                    end else if (wd_expire) begin
                        state     <= HALT;
                        bus_error <= 1'b1;
                    end
                end
                MEM_WB:         state <= FETCH;
                MEM_WR: begin
                    if (mem_ready) begin
                        state <= FETCH;
                    end else if (wd_expire) begin
                        state     <= HALT;
                        bus_error <= 1'b1;
                    end
                end
                BRANCH:         state <= FETCH;
                HALT:           state <= HALT;
                default:        state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: each step pushes the expected control word, the DUT is sampled
// on the falling edge and compared against the popped entry.
module tb_multicycle_control;
    import riscv_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       illegal_instr, bus_error;
    logic [3:0] state_o;

    multicycle_control #(.TIMEOUT(16), .STATE_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .result_src    (result_src),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       req, wr, adr, irw, pcw, rgw;
        logic [1:0] sa, sb, op, rs;
        logic       ill, berr;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Expected control word for a state, straight from the state/output table.
    function automatic exp_t e(state_t st, logic irw, logic pcw, logic ill, logic berr);
        exp_t x;
        x      = '0;
        x.st   = 4'(st);
        x.irw  = irw;
        x.pcw  = pcw;
        x.ill  = ill;
        x.berr = berr;
        case (st)
            FETCH:    begin x.req = 1'b1; x.sb = 2'b10; end
            DECODE:   begin x.sa = 2'b01; x.sb = 2'b01; end
            EXEC_R:   begin x.sa = 2'b10; x.op = 2'b10; end
            EXEC_I:   begin x.sa = 2'b10; x.sb = 2'b01; x.op = 2'b11; end
            ALU_WB:   begin x.rs = 2'b01; x.rgw = 1'b1; end
            MEM_ADDR: begin x.sa = 2'b10; x.sb = 2'b01; end
            MEM_RD:   begin x.req = 1'b1; x.adr = 1'b1; end
            MEM_WB:   begin x.rs = 2'b10; x.rgw = 1'b1; end
            MEM_WR:   begin x.req = 1'b1; x.wr = 1'b1; x.adr = 1'b1; end
            BRANCH:   begin x.sa = 2'b10; x.op = 2'b01; x.rs = 2'b01; end
            default:  ;
        endcase
        return x;
    endfunction

    function automatic exp_t e_rst();
        exp_t x;
        x     = e(FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
        x.req = 1'b0;
        return x;
    endfunction

    task automatic check(input string tag);
        exp_t obs, exp_v;
        obs = {state_o, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, bus_error};
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty observed=%h", tag, obs);
        end else begin
            exp_v = sbq.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic step(input string tag, input logic [6:0] op, input logic z,
                        input logic rdy, input exp_t x);
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        sbq.push_back(x);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        sbq.push_back(e_rst());
        check(tag);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // power-on reset: FETCH state but all enables held low
        #2;
        sbq.push_back(e_rst());
        check("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // R-type, zero-wait memory: 4 cycles
        step("r_fetch",  OP_R, 1'b0, 1'b1, e(FETCH,  1'b1, 1'b1, 1'b0, 1'b0));
        step("r_decode", OP_R, 1'b0, 1'b1, e(DECODE, 1'b0, 1'b0, 1'b0, 1'b0));
        step("r_exec",   OP_R, 1'b0, 1'b1, e(EXEC_R, 1'b0, 1'b0, 1'b0, 1'b0));
        step("r_wb",     OP_R, 1'b0, 1'b1, e(ALU_WB, 1'b0, 1'b0, 1'b0, 1'b0));

        // I-type ALU
        step("i_fetch",  OP_I, 1'b0, 1'b1, e(FETCH,  1'b1, 1'b1, 1'b0, 1'b0));
        step("i_decode", OP_I, 1'b0, 1'b1, e(DECODE, 1'b0, 1'b0, 1'b0, 1'b0));
        step("i_exec",   OP_I, 1'b0, 1'b1, e(EXEC_I, 1'b0, 1'b0, 1'b0, 1'b0));
        step("i_wb",     OP_I, 1'b0, 1'b1, e(ALU_WB, 1'b0, 1'b0, 1'b0, 1'b0));

        // LW with 3 wait cycles on fetch and on the data read: 11 cycles
        for (int i = 0; i < 3; i++)
            step("lw_fetch_wait", OP_LOAD, 1'b0, 1'b0, e(FETCH, 1'b0, 1'b0, 1'b0, 1'b0));
        step("lw_fetch",  OP_LOAD, 1'b0, 1'b1, e(FETCH,    1'b1, 1'b1, 1'b0, 1'b0));
        step("lw_decode", OP_LOAD, 1'b0, 1'b1, e(DECODE,   1'b0, 1'b0, 1'b0, 1'b0));
        step("lw_addr",   OP_LOAD, 1'b0, 1'b1, e(MEM_ADDR, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            step("lw_rd_wait", OP_LOAD, 1'b0, 1'b0, e(MEM_RD, 1'b0, 1'b0, 1'b0, 1'b0));
        step("lw_rd",     OP_LOAD, 1'b0, 1'b1, e(MEM_RD,   1'b0, 1'b0, 1'b0, 1'b0));
        step("lw_wb",     OP_LOAD, 1'b0, 1'b1, e(MEM_WB,   1'b0, 1'b0, 1'b0, 1'b0));

        // BEQ taken then not taken: 3 cycles each
        step("beq1_fetch",  OP_BRANCH, 1'b1, 1'b1, e(FETCH,  1'b1, 1'b1, 1'b0, 1'b0));
        step("beq1_decode", OP_BRANCH, 1'b1, 1'b1, e(DECODE, 1'b0, 1'b0, 1'b0, 1'b0));
        step("beq1_branch", OP_BRANCH, 1'b1, 1'b1, e(BRANCH, 1'b0, 1'b1, 1'b0, 1'b0));
        step("beq0_fetch",  OP_BRANCH, 1'b0, 1'b1, e(FETCH,  1'b1, 1'b1, 1'b0, 1'b0));
        step("beq0_decode", OP_BRANCH, 1'b0, 1'b1, e(DECODE, 1'b0, 1'b0, 1'b0, 1'b0));
        step("beq0_branch", OP_BRANCH, 1'b0, 1'b1, e(BRANCH, 1'b0, 1'b0, 1'b0, 1'b0));

        // SW, zero-wait: 4 cycles
        step("sw_fetch",  OP_STORE, 1'b0, 1'b1, e(FETCH,    1'b1, 1'b1, 1'b0, 1'b0));
        step("sw_decode", OP_STORE, 1'b0, 1'b1, e(DECODE,   1'b0, 1'b0, 1'b0, 1'b0));
        step("sw_addr",   OP_STORE, 1'b0, 1'b1, e(MEM_ADDR, 1'b0, 1'b0, 1'b0, 1'b0));
        step("sw_wr",     OP_STORE, 1'b0, 1'b1, e(MEM_WR,   1'b0, 1'b0, 1'b0, 1'b0));

        // LUI is unsupported: HALT with sticky illegal_instr, no more requests
        step("lui_fetch",  7'b0110111, 1'b0, 1'b1, e(FETCH,  1'b1, 1'b1, 1'b0, 1'b0));
        step("lui_decode", 7'b0110111, 1'b0, 1'b1, e(DECODE, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            step("lui_halt", OP_R, 1'(i), 1'(i), e(HALT, 1'b0, 1'b0, 1'b1, 1'b0));
        pulse_reset("reset_after_halt");

        // ready on the 16th stalled fetch cycle wins over the timeout
        for (int i = 0; i < 15; i++)
            step("wd_edge_wait", OP_R, 1'b0, 1'b0, e(FETCH, 1'b0, 1'b0, 1'b0, 1'b0));
        step("wd_edge_fetch",  OP_R, 1'b0, 1'b1, e(FETCH,  1'b1, 1'b1, 1'b0, 1'b0));
        step("wd_edge_decode", OP_R, 1'b0, 1'b1, e(DECODE, 1'b0, 1'b0, 1'b0, 1'b0));
        step("wd_edge_exec",   OP_R, 1'b0, 1'b1, e(EXEC_R, 1'b0, 1'b0, 1'b0, 1'b0));
        step("wd_edge_wb",     OP_R, 1'b0, 1'b1, e(ALU_WB, 1'b0, 1'b0, 1'b0, 1'b0));

        // 16 stalled fetch cycles: bus_error, request dropped the next cycle
        for (int i = 0; i < 16; i++)
            step("wd_wait", OP_R, 1'b0, 1'b0, e(FETCH, 1'b0, 1'b0, 1'b0, 1'b0));
        step("wd_halt",  OP_R, 1'b0, 1'b0, e(HALT, 1'b0, 1'b0, 1'b0, 1'b1));
        step("wd_hold",  OP_R, 1'b0, 1'b1, e(HALT, 1'b0, 1'b0, 1'b0, 1'b1));
        pulse_reset("reset_after_timeout");

        // reset asserted mid-wait in MEM_WR drops the request asynchronously
        step("ar_fetch",  OP_STORE, 1'b0, 1'b1, e(FETCH,    1'b1, 1'b1, 1'b0, 1'b0));
        step("ar_decode", OP_STORE, 1'b0, 1'b1, e(DECODE,   1'b0, 1'b0, 1'b0, 1'b0));
        step("ar_addr",   OP_STORE, 1'b0, 1'b1, e(MEM_ADDR, 1'b0, 1'b0, 1'b0, 1'b0));
        step("ar_wr_wait", OP_STORE, 1'b0, 1'b0, e(MEM_WR,  1'b0, 1'b0, 1'b0, 1'b0));
        mem_ready = 1'b0;
        sbq.push_back(e(MEM_WR, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        check("ar_wr_before");
        #1 rst_n = 1'b0;
        #1;
        sbq.push_back(e_rst());
        check("ar_async_drop");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("ar_restart", OP_R, 1'b0, 1'b1, e(FETCH,  1'b1, 1'b1, 1'b0, 1'b0));
        step("ar_decode2", OP_R, 1'b0, 1'b1, e(DECODE, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencing FSM for the RV32I core subset: R-type (0110011), I-type ALU (0010011), LW (0000011), SW (0100011), BEQ (1100011).
- Replaces per-cycle combinational decode with a state machine that steps a shared ALU, register file and single unified memory port through fetch, decode, execute, memory and writeback.
- Owns the memory request/ready handshake and a watchdog on memory latency.
- Any other opcode halts the core.

Parameters:
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before bus error; 0 disables the watchdog.
- STATE_W, 4, width of state encoding and of debug port state_o.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from instruction register
- zero  in  1  ALU zero flag (rs1 == rs2 on subtract)
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_write  out  1  request is a store (valid only with mem_req)
- adr_src  out  1  memory address: 0 = PC, 1 = alu_out register
- ir_write  out  1  load instruction register and old_pc
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = R funct decode, 11 = I funct decode
- result_src  out  2  00 = ALU result, 01 = alu_out register, 10 = memory read data
- illegal_instr  out  1  sticky: unsupported opcode decoded
- bus_error  out  1  sticky: memory watchdog expired
- state_o  out  STATE_W  current state, for debug only

Behaviour:
- Outputs are a combinational decode of the state. pc_write and ir_write in FETCH and BRANCH additionally depend on inputs (Mealy). Unlisted outputs are 0 in every state.
- Reset (rst_n low, asynchronous):
  - state = FETCH, watchdog counter = 0, illegal_instr = 0, bus_error = 0.
  - mem_req, mem_write, pc_write, ir_write and reg_write are forced 0 while rst_n = 0.
- FETCH:
  - Outputs: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 00.
  - On mem_ready: ir_write = 1 and pc_write = 1 (PC <= PC + 4), next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target into alu_out).
  - Next state by opcode: 0110011 -> EXEC_R, 0010011 -> EXEC_I, 0000011 or 0100011 -> MEM_ADDR, 1100011 -> BRANCH.
  - Any other opcode -> HALT and set illegal_instr.
- EXEC_R: alu_src_a = 10, alu_src_b = 00, alu_op = 10. Next state ALU_WB.
- EXEC_I: alu_src_a = 10, alu_src_b = 01, alu_op = 11. Next state ALU_WB.
- ALU_WB: result_src = 01, reg_write = 1. Next state FETCH.
- MEM_ADDR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Next state MEM_RD for load, MEM_WR for store; opcode is held stable by the instruction register.
- MEM_RD: mem_req = 1, adr_src = 1. On mem_ready -> MEM_WB, otherwise stay.
- MEM_WB: result_src = 10, reg_write = 1. Next state FETCH.
- MEM_WR: mem_req = 1, mem_write = 1, adr_src = 1. On mem_ready -> FETCH, otherwise stay.
- BRANCH:
  - Outputs: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 01.
  - pc_write = zero. Next state FETCH regardless of zero.
- HALT: all enables 0. Stays in HALT until reset; the sticky flags hold.
- Cycle counts with zero-wait memory (mem_ready high on first request cycle): R/I = 4, BEQ = 3, LW = 5, SW = 4.
- Watchdog:
  - Counter increments each cycle mem_req = 1 and mem_ready = 0; it clears on mem_ready or when leaving a request state.
  - If the counter reaches TIMEOUT with mem_ready still 0: go to HALT, set bus_error, drop mem_req next cycle.
  - If mem_ready and the timeout coincide, mem_ready wins.
- Reset mid-request drops mem_req immediately, asynchronously. Memory must abandon the transaction.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - a state_t enum (FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, HALT);
  - enums for alu_src_a, alu_src_b, alu_op and result_src encodings, shared with the datapath muxes.
- One sub-module: mem_watchdog, the parameterised timeout counter with inputs req and ready and a single-cycle expire output.
- The FSM itself stays in one module.

Test Plan:
- R-type add (opcode 0110011), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, ALU_WB, FETCH; reg_write = 1 only in cycle 4; pc_write = 1 only in cycle 1.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> mem_req held continuously, no spurious ir_write; total 11 cycles; reg_write with result_src = 10 exactly once.
- BEQ with zero = 1, then with zero = 0 -> pc_write in BRANCH is 1, then 0; both return to FETCH after 3 cycles; SW -> mem_write = 1 with adr_src = 1 only in MEM_WR.
- Opcode 0110111 (LUI, unsupported) -> HALT after DECODE; illegal_instr = 1 sticky; no further mem_req until rst_n pulse.
- TIMEOUT = 16, mem_ready held 0 in FETCH -> bus_error set after 16 request cycles, mem_req low next cycle; repeat with mem_ready on cycle 16 -> no error.
- rst_n asserted in MEM_WR mid-wait -> mem_req and mem_write drop the same cycle, asynchronously; after release the FSM starts in FETCH with both flags 0.
